// File: rtl/blit_cmd_queue.sv
// ============================================================================
// Module   : blit_cmd_queue
// Brief    : CPU-staged blitter command FIFO with first-word fall-through head.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blit_cmd_queue #(
    parameter int DEPTH = 16,
    parameter int LW    = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_write,
    input  logic [1:0]    cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [103:0]  p0_cmd,
    output logic          p0_cmd_valid,
    input  logic          cmd_next,
    input  logic          stall,
    output logic [LW-1:0] fifo_level,
    output logic          fifo_full
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [LW-1:0] c_FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] c_ONE_LVL  = LW'(1);
    localparam logic [c_AW-1:0] c_ONE_PTR = c_AW'(1);

    logic [103:0]    r_mem [DEPTH];
    logic [31:0]     r_stage0;
    logic [31:0]     r_stage1;
    logic [31:0]     r_stage2;
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic w_commit;
    logic w_push;
    logic w_pop;

    // Reset gating keeps the handshake quiet while the block is held in reset.
    assign w_commit = cpu_write && (cpu_addr == 2'd3);
    assign cpu_ack  = reset_n && cpu_write && (!w_commit || !fifo_full);
    assign w_push   = cpu_ack && w_commit;

    assign fifo_level   = r_level;
    assign fifo_full    = (r_level == c_FULL_LVL);
    assign p0_cmd_valid = (r_level != '0);
    assign p0_cmd       = r_mem[r_rd_ptr];
    assign w_pop        = cmd_next && p0_cmd_valid && !stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stage0 <= '0;
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else if (cpu_ack) begin
            case (cpu_addr)
                2'd0:    r_stage0 <= cpu_wdata;
                2'd1:    r_stage1 <= cpu_wdata;
                2'd2:    r_stage2 <= cpu_wdata;
                default: ;
            endcase
        end
    end

    // Storage is not reset; validity is tracked solely by the level counter.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cpu_wdata[7:0], r_stage2, r_stage1, r_stage0};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_ONE_LVL;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_ONE_LVL;
            end
        end
    end

endmodule

`default_nettype wire
